video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
Parametrised, mode-switchable raster timing generator for the HDMI output path. It produces pixel/line counters, hsync, vsync, data-enable, field and frame/line strobes from a shadowed set of mode timings, and supports progressive and interlaced modes. Mode changes are accepted only at frame boundaries so the sink never sees a torn frame. It sits between the mode-select logic and the pattern/overlay generators.

Parameters:
CW, 12, width of all counters and timing fields
FRAME_CNT_W, 8, width of frame_count output

Ports:
clock  in  1  pixel clock
reset  in  1  synchronous, active-high
mode_h_active, mode_h_front_porch, mode_h_sync, mode_h_total  in  CW each  horizontal timings, in pixels
mode_v_active, mode_v_front_porch, mode_v_sync  in  CW each  vertical timings, in lines
mode_v_total_1, mode_v_total_2  in  CW each  lines in field 0 / field 1
mode_h_sync_pol, mode_v_sync_pol, mode_interlaced  in  1 each  1 = active-high sync; 1 = interlaced
mode_update  in  1  request to load the mode_* inputs at the next frame boundary
counterX, counterY  out  CW each  current pixel/line
hsync, vsync  out  1 each  polarity-applied sync
de  out  1  high when counterX < h_active and counterY < v_active
field  out  1  current field (constant 0 in progressive)
line_start, frame_start  out  1 each  single-cycle strobes
frame_count  out  FRAME_CNT_W  completed-frame counter, wraps
update_pending  out  1  mode_update accepted, not yet applied

Behaviour:
- Shadow registers hold the active mode. All timing decisions use the shadow copy only; mode_* inputs are ignored except at load.
- Reset: shadow <= mode_* inputs; counters 0; field 0; frame_count 0; update_pending 0; de 0; line_start 0; frame_start 0; hsync = ~h_sync_pol; vsync = ~v_sync_pol. The shadow polarity is the one just loaded.
- Counter step, every cycle outside reset:
  - X increments; at h_total-1 it wraps to 0 and Y advances.
  - Y wraps at Vt-1, where Vt = (interlaced && field) ? v_total_2 : v_total_1.
  - Progressive: field stays 0 and every Y wrap ends a frame.
  - Interlaced: field toggles on each Y wrap; a frame ends on the wrap out of field 1.
- Outputs are registered, latency 1. counterX/counterY, hsync, vsync, de, line_start and frame_start all describe the same pixel: the internal counter value of the previous cycle.
- line_start = 1 when the output X is 0. frame_start = 1 when output X = 0, output Y = 0 and output field = 0.
- hsync is active while X is in [HS, HS+h_sync), where HS = h_active + h_front_porch.
- vsync starts and ends at hsync leading edge (VESA DMT 3.5), with VS = v_active + v_front_porch:
  - Line VS-1: active for X >= HS.
  - Lines VS .. VS+v_sync-2: fully active.
  - Line VS+v_sync-1: active for X < HS.
- Interlaced field 1: the vsync start and end points shift by h_total/2 (floor). The compare point is HS + h_total/2 modulo h_total; if that value is >= h_total, subtract h_total and apply it one line later.
- Mode update:
  - A mode_update pulse sets update_pending. If several pulses arrive before the boundary, the inputs present on the boundary cycle are the ones loaded.
  - The load happens on the cycle the internal counters wrap to X=0, Y=0 at a frame end. On that same cycle: field <= 0, frame_count += 1, update_pending <= 0.
  - mode_update on the boundary cycle itself loads immediately and leaves update_pending at 0.
- frame_count increments on every frame end and wraps at 2^FRAME_CNT_W.
- Degenerate timings (h_total=0, Vt=0) are not supported. The counters must still hold at 0 and must not overflow.
- Reset mid-frame: on the next cycle all outputs equal their reset values and counting restarts from 0,0.

Test Plan:
1. Progressive 640x480, 800 total pixels, 525 total lines, HFP 16, HS 96, VFP 10, VS 2, negative polarity:
   - hsync low for X 656..751.
   - vsync falls on Y489/X656 and rises on Y491/X656.
   - de high for exactly 307200 cycles per frame.
   - frame_start period 420000 cycles.
2. Interlaced 1080i, 2200 total pixels, v_total_1=562, v_total_2=563:
   - field toggles every 562/563 lines.
   - Field 1 vsync edges land 1100 pixels after the field 0 edges.
   - frame_start appears only at field 0 start.
3. Mode switch:
   - Pulse mode_update at mid-frame with 1280x720 inputs.
   - update_pending=1 until the wrap.
   - The first frame after the wrap shows h_total=1650.
   - The previous frame keeps its original timing.
4. Change mode_* inputs without mode_update, then run 3 frames -> timing unchanged, frame_count advances by 3.
5. Assert reset at X=300, Y=200 for 1 cycle:
   - Next output cycle: counters 0, de=0, syncs inactive.
   - The new shadow is loaded from the inputs present during reset.
6. frame_count with FRAME_CNT_W=2: run 5 frames -> sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : video_timing_gen
//  Brief    : Mode-switchable progressive/interlaced raster timing generator
//             with shadowed timings applied only at frame boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int CW          = 12,
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CW-1:0]          mode_h_active,
    input  logic [CW-1:0]          mode_h_front_porch,
    input  logic [CW-1:0]          mode_h_sync,
    input  logic [CW-1:0]          mode_h_total,
    input  logic [CW-1:0]          mode_v_active,
    input  logic [CW-1:0]          mode_v_front_porch,
    input  logic [CW-1:0]          mode_v_sync,
    input  logic [CW-1:0]          mode_v_total_1,
    input  logic [CW-1:0]          mode_v_total_2,
    input  logic                   mode_h_sync_pol,
    input  logic                   mode_v_sync_pol,
    input  logic                   mode_interlaced,
    input  logic                   mode_update,
    output logic [CW-1:0]          counterX,
    output logic [CW-1:0]          counterY,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic                   field,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   update_pending
);

    localparam int                    c_EXT_W   = CW + 2;
    localparam logic [CW-1:0]         c_ONE     = CW'(1);
    localparam logic [c_EXT_W-1:0]    c_EXT_ONE = c_EXT_W'(1);

    // Shadow copy of the active mode
    logic [CW-1:0] r_h_active, r_h_front_porch, r_h_sync, r_h_total;
    logic [CW-1:0] r_v_active, r_v_front_porch, r_v_sync;
    logic [CW-1:0] r_v_total_1, r_v_total_2;
    logic          r_h_sync_pol, r_v_sync_pol, r_interlaced;

    // Internal raster position
    logic [CW-1:0] r_x, r_y;
    logic          r_field;

    // Registered outputs
    logic [CW-1:0]          r_counter_x, r_counter_y;
    logic                   r_hsync, r_vsync, r_de, r_field_out;
    logic                   r_line_start, r_frame_start;
    logic [FRAME_CNT_W-1:0] r_frame_count;
    logic                   r_update_pending;

    logic [CW-1:0]      w_vt;
    logic               w_x_last, w_y_last, w_frame_end, w_load;
    logic [CW-1:0]      w_x_next, w_y_next;
    logic               w_field_next;
    logic [c_EXT_W-1:0] w_x_ext, w_y_p1, w_ht_ext, w_half;
    logic [c_EXT_W-1:0] w_hs_start, w_hs_end;
    logic [c_EXT_W-1:0] w_vp_raw, w_vp, w_vs_first, w_vs_last;
    logic               w_shift, w_vp_wrap;
    logic               w_hs_act, w_vs_act, w_de;

    // ------------------------------------------------------------------
    // Counter stepping; a zero total collapses the counter onto 0
    // ------------------------------------------------------------------
    assign w_vt         = (r_interlaced && r_field) ? r_v_total_2 : r_v_total_1;
    assign w_x_last     = (r_h_total == '0) || (r_x >= r_h_total - c_ONE);
    assign w_y_last     = (w_vt == '0) || (r_y >= w_vt - c_ONE);
    assign w_frame_end  = w_x_last && w_y_last && (!r_interlaced || r_field);
    assign w_x_next     = w_x_last ? '0 : r_x + c_ONE;
    assign w_y_next     = !w_x_last ? r_y : (w_y_last ? '0 : r_y + c_ONE);
    assign w_field_next = (w_x_last && w_y_last) ? (r_interlaced && !r_field) : r_field;
    assign w_load       = reset || (w_frame_end && (r_update_pending || mode_update));

    // ------------------------------------------------------------------
    // Sync and data-enable decode, in widened arithmetic to avoid wrap
    // ------------------------------------------------------------------
    assign w_x_ext    = {2'b00, r_x};
    assign w_y_p1     = {2'b00, r_y} + c_EXT_ONE;
    assign w_ht_ext   = {2'b00, r_h_total};
    assign w_half     = {3'b000, r_h_total[CW-1:1]};
    assign w_hs_start = {2'b00, r_h_active} + {2'b00, r_h_front_porch};
    assign w_hs_end   = w_hs_start + {2'b00, r_h_sync};
    assign w_hs_act   = (w_x_ext >= w_hs_start) && (w_x_ext < w_hs_end);

    // Field 1 moves the vsync edges by half a line, possibly into the next line
    assign w_shift    = r_interlaced && r_field;
    assign w_vp_raw   = w_hs_start + (w_shift ? w_half : '0);
    assign w_vp_wrap  = w_shift && (w_vp_raw >= w_ht_ext);
    assign w_vp       = w_vp_wrap ? (w_vp_raw - w_ht_ext) : w_vp_raw;
    assign w_vs_first = {2'b00, r_v_active} + {2'b00, r_v_front_porch}
                      + (w_vp_wrap ? c_EXT_ONE : '0);
    assign w_vs_last  = w_vs_first + {2'b00, r_v_sync};

    // Comparing y+1 keeps the "line before VS" case free of underflow
    assign w_vs_act   = (r_v_sync != '0) &&
                        (((w_y_p1 == w_vs_first) && (w_x_ext >= w_vp)) ||
                         ((w_y_p1 >  w_vs_first) && (w_y_p1 < w_vs_last)) ||
                         ((w_y_p1 == w_vs_last)  && (w_x_ext <  w_vp)));

    assign w_de       = (r_x < r_h_active) && (r_y < r_v_active);

    // ------------------------------------------------------------------
    // Shadow mode registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_load) begin
            r_h_active      <= mode_h_active;
            r_h_front_porch <= mode_h_front_porch;
            r_h_sync        <= mode_h_sync;
            r_h_total       <= mode_h_total;
            r_v_active      <= mode_v_active;
            r_v_front_porch <= mode_v_front_porch;
            r_v_sync        <= mode_v_sync;
            r_v_total_1     <= mode_v_total_1;
            r_v_total_2     <= mode_v_total_2;
            r_h_sync_pol    <= mode_h_sync_pol;
            r_v_sync_pol    <= mode_v_sync_pol;
            r_interlaced    <= mode_interlaced;
        end
    end

    // ------------------------------------------------------------------
    // Raster counters, frame bookkeeping and output register stage
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_x              <= '0;
            r_y              <= '0;
            r_field          <= 1'b0;
            r_counter_x      <= '0;
            r_counter_y      <= '0;
            r_hsync          <= ~mode_h_sync_pol;
            r_vsync          <= ~mode_v_sync_pol;
            r_de             <= 1'b0;
            r_field_out      <= 1'b0;
            r_line_start     <= 1'b0;
            r_frame_start    <= 1'b0;
            r_frame_count    <= '0;
            r_update_pending <= 1'b0;
        end else begin
            r_counter_x   <= r_x;
            r_counter_y   <= r_y;
            r_hsync       <= ~(w_hs_act ^ r_h_sync_pol);
            r_vsync       <= ~(w_vs_act ^ r_v_sync_pol);
            r_de          <= w_de;
            r_field_out   <= r_field;
            r_line_start  <= (r_x == '0);
            r_frame_start <= (r_x == '0) && (r_y == '0) && !r_field;

            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_field <= w_field_next;

            if (w_frame_end) begin
                r_frame_count    <= r_frame_count + FRAME_CNT_W'(1);
                r_update_pending <= 1'b0;
            end else if (mode_update) begin
                r_update_pending <= 1'b1;
            end
        end
    end

    assign counterX       = r_counter_x;
    assign counterY       = r_counter_y;
    assign hsync          = r_hsync;
    assign vsync          = r_vsync;
    assign de             = r_de;
    assign field          = r_field_out;
    assign line_start     = r_line_start;
    assign frame_start    = r_frame_start;
    assign frame_count    = r_frame_count;
    assign update_pending = r_update_pending;

endmodule
`default_nettype wire
